// File: rtl/rtn_addr_stack.sv
// rtl/rtn_addr_stack.sv - return-address stack with overflow/underflow detection and sticky error state
module rtn_addr_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Push_Req,
    input  logic [ADDR_W-1:0] Push_Addr,
    input  logic              Pop_Req,
    input  logic              Flush,
    input  logic              Err_Clr,
    output logic [ADDR_W-1:0] Return_Addr,
    output logic              Stack_Empty,
    output logic              Stack_Full,
    output logic [CNT_W-1:0]  Depth,
    output logic              Stack_Err,
    output logic [1:0]        Err_Code
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   sp_q;
    logic [CNT_W-1:0]   sp_d;
    logic [1:0]         code_q;
    logic [1:0]         code_d;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   sp_m1;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               sp_zero;
    logic [ADDR_W-1:0]  mem [DEPTH];

    assign sp_m1    = sp_q - ONE_CNT;
    assign top_idx  = sp_m1[IDX_W-1:0];
    assign push_idx = sp_q[IDX_W-1:0];
    assign sp_zero  = (sp_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            sp_q    <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        code_d  = code_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        case (state_q)
            RUN: begin
                if (Flush || Err_Clr) begin
                    sp_d   = '0;
                    code_d = 2'b00;
                end else if (Push_Req && Pop_Req) begin
                    wr_en = 1'b1;
                    if (!sp_zero) begin
                        // CALL and RET in one cycle: the new return address replaces the top
                        wr_idx = top_idx;
                    end else begin
                        wr_idx    = '0;
                        sp_d      = ONE_CNT;
                        code_d[0] = 1'b1;
                        state_d   = ERR;
                    end
                end else if (Push_Req) begin
                    if (sp_q < FULL_CNT) begin
                        wr_en  = 1'b1;
                        wr_idx = push_idx;
                        sp_d   = sp_q + ONE_CNT;
                    end else begin
                        code_d[1] = 1'b1;
                        state_d   = ERR;
                    end
                end else if (Pop_Req) begin
                    if (!sp_zero) begin
                        sp_d = sp_m1;
                    end else begin
                        code_d[0] = 1'b1;
                        state_d   = ERR;
                    end
                end
            end
            ERR: begin
                if (Err_Clr) begin
                    sp_d    = '0;
                    code_d  = 2'b00;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Entries are deliberately not reset; sp alone defines what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= Push_Addr;
        end
    end

    assign Return_Addr = sp_zero ? '0 : mem[top_idx];
    assign Stack_Empty = sp_zero;
    assign Stack_Full  = (sp_q == FULL_CNT);
    assign Depth       = sp_q;
    assign Stack_Err   = (state_q == ERR);
    assign Err_Code    = code_q;

endmodule

// File: tb/tb_rtn_addr_stack.sv
// tb/tb_rtn_addr_stack.sv - scoreboard bench for rtn_addr_stack
module tb_rtn_addr_stack;

    logic       clk;
    logic       reset_n;
    logic       Push_Req;
    logic [7:0] Push_Addr;
    logic       Pop_Req;
    logic       Flush;
    logic       Err_Clr;
    logic [7:0] Return_Addr;
    logic       Stack_Empty;
    logic       Stack_Full;
    logic [3:0] Depth;
    logic       Stack_Err;
    logic [1:0] Err_Code;

    typedef struct packed {
        logic       push;
        logic [7:0] addr;
        logic       pop;
        logic       flush;
        logic       clr;
    } stim_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [16:0] sb_q [$];

    rtn_addr_stack #(.ADDR_W(8), .DEPTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Push_Req    (Push_Req),
        .Push_Addr   (Push_Addr),
        .Pop_Req     (Pop_Req),
        .Flush       (Flush),
        .Err_Clr     (Err_Clr),
        .Return_Addr (Return_Addr),
        .Stack_Empty (Stack_Empty),
        .Stack_Full  (Stack_Full),
        .Depth       (Depth),
        .Stack_Err   (Stack_Err),
        .Err_Code    (Err_Code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    function automatic stim_t mk_s(input logic push, input logic [7:0] addr, input logic pop,
                                   input logic flush, input logic clr);
        stim_t s;
        s.push = push; s.addr = addr; s.pop = pop; s.flush = flush; s.clr = clr;
        return s;
    endfunction

    // Expected output vector: {Return_Addr, Empty, Full, Depth, Stack_Err, Err_Code}
    function automatic logic [16:0] mk_e(input logic [7:0] ret, input logic [3:0] depth,
                                         input logic err, input logic [1:0] code);
        return {ret, depth == 4'd0, depth == 4'd8, depth, err, code};
    endfunction

    function automatic logic [16:0] observe();
        return {Return_Addr, Stack_Empty, Stack_Full, Depth, Stack_Err, Err_Code};
    endfunction

    task automatic drive(input stim_t s);
        Push_Req  = s.push;
        Push_Addr = s.addr;
        Pop_Req   = s.pop;
        Flush     = s.flush;
        Err_Clr   = s.clr;
        @(posedge clk);
        #1;
        Push_Req  = 1'b0;
        Push_Addr = 8'h00;
        Pop_Req   = 1'b0;
        Flush     = 1'b0;
        Err_Clr   = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got, exp_v;
        reset_n = 1'b0;
        Push_Req = 1'b1; Push_Addr = 8'h5A; Pop_Req = 1'b0; Flush = 1'b0; Err_Clr = 1'b0;
        sb_q.push_back(mk_e(8'h00, 4'd0, 1'b0, 2'b00));
        repeat (2) @(posedge clk);
        #1;
        got = observe();
        exp_v = sb_q.pop_front();
        n_vec++;
        if (got !== exp_v) begin
            n_miss++;
            $display("FAIL reset: got %h expected %h", got, exp_v);
        end
        Push_Req = 1'b0; Push_Addr = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic test_push_pop();
        stim_t st [$];
        logic [16:0] ex [$];
        logic [16:0] got, exp_v;
        st.push_back(mk_s(1, 8'h10, 0, 0, 0)); ex.push_back(mk_e(8'h10, 4'd1, 0, 2'b00));
        st.push_back(mk_s(1, 8'h20, 0, 0, 0)); ex.push_back(mk_e(8'h20, 4'd2, 0, 2'b00));
        st.push_back(mk_s(1, 8'h30, 0, 0, 0)); ex.push_back(mk_e(8'h30, 4'd3, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h20, 4'd2, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h10, 4'd1, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        for (int i = 0; i < st.size(); i++) begin
            sb_q.push_back(ex[i]);
            drive(st[i]);
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL push_pop step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t st [$];
        logic [16:0] ex [$];
        logic [16:0] got, exp_v;
        for (int k = 1; k <= 8; k++) begin
            st.push_back(mk_s(1, 8'(k), 0, 0, 0));
            ex.push_back(mk_e(8'(k), 4'(k), 0, 2'b00));
        end
        st.push_back(mk_s(1, 8'h99, 0, 0, 0)); ex.push_back(mk_e(8'h08, 4'd8, 1, 2'b10));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h08, 4'd8, 1, 2'b10));
        st.push_back(mk_s(0, 8'h00, 0, 0, 1)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        for (int i = 0; i < st.size(); i++) begin
            sb_q.push_back(ex[i]);
            drive(st[i]);
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL overflow step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_underflow();
        stim_t st [$];
        logic [16:0] ex [$];
        logic [16:0] got, exp_v;
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h00, 4'd0, 1, 2'b01));
        st.push_back(mk_s(1, 8'h44, 0, 0, 0)); ex.push_back(mk_e(8'h00, 4'd0, 1, 2'b01));
        st.push_back(mk_s(1, 8'h45, 1, 0, 0)); ex.push_back(mk_e(8'h00, 4'd0, 1, 2'b01));
        st.push_back(mk_s(0, 8'h00, 0, 1, 0)); ex.push_back(mk_e(8'h00, 4'd0, 1, 2'b01));
        st.push_back(mk_s(0, 8'h00, 0, 0, 1)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        st.push_back(mk_s(1, 8'h46, 0, 0, 0)); ex.push_back(mk_e(8'h46, 4'd1, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        for (int i = 0; i < st.size(); i++) begin
            sb_q.push_back(ex[i]);
            drive(st[i]);
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL underflow step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st [$];
        logic [16:0] ex [$];
        logic [16:0] got, exp_v;
        st.push_back(mk_s(1, 8'h10, 0, 0, 0)); ex.push_back(mk_e(8'h10, 4'd1, 0, 2'b00));
        st.push_back(mk_s(1, 8'h20, 0, 0, 0)); ex.push_back(mk_e(8'h20, 4'd2, 0, 2'b00));
        st.push_back(mk_s(1, 8'h55, 1, 0, 0)); ex.push_back(mk_e(8'h55, 4'd2, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'h10, 4'd1, 0, 2'b00));
        for (int k = 1; k <= 7; k++) begin
            st.push_back(mk_s(1, 8'hA0 + 8'(k), 0, 0, 0));
            ex.push_back(mk_e(8'hA0 + 8'(k), 4'(k + 1), 0, 2'b00));
        end
        st.push_back(mk_s(1, 8'h77, 1, 0, 0)); ex.push_back(mk_e(8'h77, 4'd8, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 0, 0)); ex.push_back(mk_e(8'hA6, 4'd7, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 0, 0, 1)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        st.push_back(mk_s(1, 8'h66, 1, 0, 0)); ex.push_back(mk_e(8'h66, 4'd1, 1, 2'b01));
        st.push_back(mk_s(0, 8'h00, 0, 0, 1)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        for (int i = 0; i < st.size(); i++) begin
            sb_q.push_back(ex[i]);
            drive(st[i]);
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st [$];
        logic [16:0] ex [$];
        logic [16:0] got, exp_v;
        for (int k = 1; k <= 4; k++) begin
            st.push_back(mk_s(1, 8'h40 + 8'(k), 0, 0, 0));
            ex.push_back(mk_e(8'h40 + 8'(k), 4'(k), 0, 2'b00));
        end
        st.push_back(mk_s(0, 8'h00, 0, 1, 0)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        st.push_back(mk_s(1, 8'h12, 0, 1, 0)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        st.push_back(mk_s(0, 8'h00, 1, 1, 0)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        st.push_back(mk_s(1, 8'h33, 0, 0, 0)); ex.push_back(mk_e(8'h33, 4'd1, 0, 2'b00));
        st.push_back(mk_s(1, 8'h34, 0, 0, 0)); ex.push_back(mk_e(8'h34, 4'd2, 0, 2'b00));
        st.push_back(mk_s(1, 8'h35, 0, 0, 1)); ex.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
        for (int i = 0; i < st.size(); i++) begin
            sb_q.push_back(ex[i]);
            drive(st[i]);
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL flush step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] got, exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0: reset with Depth=5 in RUN; pass 1: reset while held in ERR at full
            for (int k = 1; k <= ((pass == 0) ? 5 : 9); k++) begin
                sb_q.push_back((k <= 8) ? mk_e(8'hC0 + 8'(k), 4'(k), 0, 2'b00)
                                        : mk_e(8'hC8, 4'd8, 1, 2'b10));
                drive(mk_s(1, 8'hC0 + 8'(k), 0, 0, 0));
                got = observe();
                exp_v = sb_q.pop_front();
                n_vec++;
                if (got !== exp_v) begin
                    n_miss++;
                    $display("FAIL async_reset pass %0d setup %0d: got %h expected %h", pass, k, got, exp_v);
                end
            end
            #2;
            reset_n = 1'b0;
            sb_q.push_back(mk_e(8'h00, 4'd0, 0, 2'b00));
            #1;
            got = observe();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_miss++;
                $display("FAIL async_reset pass %0d mid-cycle: got %h expected %h", pass, got, exp_v);
            end
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end
        sb_q.push_back(mk_e(8'hAB, 4'd1, 0, 2'b00));
        drive(mk_s(1, 8'hAB, 0, 0, 0));
        got = observe();
        exp_v = sb_q.pop_front();
        n_vec++;
        if (got !== exp_v) begin
            n_miss++;
            $display("FAIL async_reset recovery: got %h expected %h", got, exp_v);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        Push_Req  = 1'b0;
        Push_Addr = 8'h00;
        Pop_Req   = 1'b0;
        Flush     = 1'b0;
        Err_Clr   = 1'b0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
